// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: duty-cycle ramp controller for a Hall-commutated motor.
// It slews the 4-bit PWM duty toward the requested target one LSB every
// RAMP_DIV clocks, spins down on EN=0, and latches a fault on an invalid
// Hall code or when the rotor stops moving while it is being driven.
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_DIV    = 1000,    // clocks per one-LSB duty step, 2..65535
    parameter int unsigned STALL_LIMIT = 100000   // clocks without a Hall edge before stall, 4..2^20-1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] target,
    input  logic [2:0] h,
    output logic [3:0] duty,
    output logic [2:0] state,
    output logic       fault,
    output logic [1:0] flt_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_RAMP  = 3'b001,
        S_RUN   = 3'b010,
        S_STOP  = 3'b011,
        S_FAULT = 3'b100
    } state_t;

    localparam logic [1:0]  CODE_NONE  = 2'b00;
    localparam logic [1:0]  CODE_HALL  = 2'b01;
    localparam logic [1:0]  CODE_STALL = 2'b10;
    localparam logic [15:0] RDIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [19:0] STALL_LAST = 20'(STALL_LIMIT - 1);

    state_t      state_q, state_nx;
    logic [3:0]  duty_nx;
    logic [15:0] rcnt, rcnt_nx;
    logic [1:0]  code_nx;
    logic [19:0] stall_cnt;

    // Hall pipeline: [0] metastability flop, [1] synchronized HS, [2] HS_prev
    logic [2:0][2:0] hpipe;
    logic [2:0]      hs, hs_prev;
    logic            hall_tr, hall_bad, stall_hit, driving, step_tick;

    assign hs      = hpipe[1];
    assign hs_prev = hpipe[2];
    assign hall_tr  = (hs != hs_prev);
    assign hall_bad = (hs == 3'b000) || (hs == 3'b111);

    // Fault monitoring is only armed while the motor is being driven
    assign driving   = (state_q == S_RAMP) || (state_q == S_RUN) || (state_q == S_STOP);
    assign stall_hit = (stall_cnt == STALL_LAST);
    assign step_tick = (rcnt == RDIV_LAST);

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hpipe <= '0;
        else        hpipe <= {hpipe[1:0], h};
    end

    // Stall counter: time since the last Hall edge while torque is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state_q == S_IDLE || state_q == S_FAULT || hall_tr || duty == 4'd0)
            stall_cnt <= '0;
        else if (stall_cnt != '1)
            stall_cnt <= stall_cnt + 20'd1;
    end

    // State register together with the registered duty, ramp divider and fault code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            duty     <= 4'd0;
            rcnt     <= 16'd0;
            flt_code <= CODE_NONE;
        end else begin
            state_q  <= state_nx;
            duty     <= duty_nx;
            rcnt     <= rcnt_nx;
            flt_code <= code_nx;
        end
    end

    // Next-state logic; a detected fault overrides every other transition
    always_comb begin
        state_nx = state_q;
        duty_nx  = duty;
        rcnt_nx  = rcnt;
        code_nx  = flt_code;
        if (driving && (hall_bad || stall_hit)) begin
            // Invalid Hall is the more specific cause, so it wins a tie
            state_nx = S_FAULT;
            duty_nx  = 4'd0;
            rcnt_nx  = 16'd0;
            code_nx  = hall_bad ? CODE_HALL : CODE_STALL;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    duty_nx = 4'd0;
                    rcnt_nx = 16'd0;
                    if (en && target != 4'd0) state_nx = S_RAMP;
                end
                S_RAMP: begin
                    if (!en) begin
                        // Divider phase carries over into the spin-down
                        state_nx = S_STOP;
                    end else if (duty == target) begin
                        state_nx = S_RUN;
                        rcnt_nx  = 16'd0;
                    end else if (step_tick) begin
                        rcnt_nx = 16'd0;
                        if (duty < target) begin
                            if (duty != 4'hF) duty_nx = duty + 4'd1;
                        end else begin
                            if (duty != 4'h0) duty_nx = duty - 4'd1;
                        end
                    end else begin
                        rcnt_nx = rcnt + 16'd1;
                    end
                end
                S_RUN: begin
                    rcnt_nx = 16'd0;
                    if (!en)                  state_nx = S_STOP;
                    else if (target != duty)  state_nx = S_RAMP;
                end
                S_STOP: begin
                    if (duty == 4'd0) begin
                        state_nx = S_IDLE;
                        rcnt_nx  = 16'd0;
                    end else if (en) begin
                        // Resume from the current duty rather than from zero
                        state_nx = S_RAMP;
                        rcnt_nx  = 16'd0;
                    end else if (step_tick) begin
                        rcnt_nx = 16'd0;
                        duty_nx = duty - 4'd1;
                    end else begin
                        rcnt_nx = rcnt + 16'd1;
                    end
                end
                S_FAULT: begin
                    duty_nx = 4'd0;
                    rcnt_nx = 16'd0;
                    // Only an explicit run-request drop acknowledges the fault
                    if (!en) begin
                        state_nx = S_IDLE;
                        code_nx  = CODE_NONE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    duty_nx  = 4'd0;
                    rcnt_nx  = 16'd0;
                    code_nx  = CODE_NONE;
                end
            endcase
        end
    end

    // Outputs come straight from the registers
    always_comb begin
        state = state_q;
        fault = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed test of motor_ramp_ctrl with RAMP_DIV=4, STALL_LIMIT=64.
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] target = 4'd0;
    logic [2:0] h = 3'b001;
    logic [3:0] duty;
    logic [2:0] state;
    logic       fault;
    logic [1:0] flt_code;

    int checks = 0;
    int errors = 0;

    // Hall rotation model, advanced from tick()
    logic [2:0] hseq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    int  hidx = 0;
    int  hcnt = 0;
    bit  spin = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'b000, ST_RAMP = 3'b001, ST_RUN = 3'b010,
                           ST_STOP = 3'b011, ST_FLT = 3'b100;

    motor_ramp_ctrl #(.RAMP_DIV(4), .STALL_LIMIT(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .target   (target),
        .h        (h),
        .duty     (duty),
        .state    (state),
        .fault    (fault),
        .flt_code (flt_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; samples land 1 ns after each edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (spin) begin
                hcnt++;
                if (hcnt == 20) begin
                    hcnt = 0;
                    hidx = (hidx + 1) % 6;
                    h = hseq[hidx];
                end
            end
        end
    endtask

    // From IDLE: rotate Hall, request target t, expect RUN at duty t after 4*t+2 edges
    task automatic spin_to_run(input logic [3:0] t);
        h = hseq[hidx];
        spin = 1'b1;
        tick(3);
        en = 1'b1;
        target = t;
        tick(4 * int'(t) + 2);
        chk("run_state", {5'd0, state}, {5'd0, ST_RUN});
        chk("run_duty", {4'd0, duty}, {4'd0, t});
    endtask

    // Stop rotation; the switch to 011 becomes the last Hall edge
    task automatic freeze_hall();
        spin = 1'b0;
        if (h == 3'b011) begin
            h = 3'b010;
            tick(3);
        end
        h = 3'b011;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", {5'd0, state}, 8'h00);
        chk("rst_duty", {4'd0, duty}, 8'h00);
        chk("rst_fault", {7'd0, fault}, 8'h00);
        chk("rst_code", {6'd0, flt_code}, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // EN with TARGET=0 stays in IDLE
        en = 1'b1;
        target = 4'd0;
        tick(3);
        chk("idle_t0_state", {5'd0, state}, {5'd0, ST_IDLE});
        chk("idle_t0_duty", {4'd0, duty}, 8'h00);

        // Spin-up 0..8, one step per 4 clocks
        target = 4'd8;
        tick(1);
        chk("up_enter", {5'd0, state}, {5'd0, ST_RAMP});
        chk("up_duty0", {4'd0, duty}, 8'h00);
        for (int n = 1; n <= 8; n++) begin
            tick(3);
            chk("up_hold", {4'd0, duty}, 8'(n - 1));
            tick(1);
            chk("up_step", {4'd0, duty}, 8'(n));
        end
        tick(1);
        chk("up_run", {5'd0, state}, {5'd0, ST_RUN});
        chk("up_nofault", {5'd0, fault, flt_code}, 8'h00);

        // Retarget down to 3
        target = 4'd3;
        tick(1);
        chk("dn_enter", {5'd0, state}, {5'd0, ST_RAMP});
        for (int n = 1; n <= 5; n++) begin
            tick(4);
            chk("dn_step", {4'd0, duty}, 8'(8 - n));
        end
        tick(1);
        chk("dn_run", {5'd0, state}, {5'd0, ST_RUN});

        // Spin-down from 3 in 12 clocks, then IDLE
        en = 1'b0;
        tick(1);
        chk("stop_enter", {5'd0, state}, {5'd0, ST_STOP});
        for (int n = 1; n <= 3; n++) begin
            tick(4);
            chk("stop_step", {4'd0, duty}, 8'(3 - n));
        end
        tick(1);
        chk("stop_idle", {5'd0, state}, {5'd0, ST_IDLE});

        // Invalid Hall: 2 synchronizer clocks plus 1
        spin_to_run(4'd2);
        spin = 1'b0;
        h = 3'b111;
        tick(2);
        chk("inv_not_yet", {7'd0, fault}, 8'h00);
        tick(1);
        chk("inv_state", {5'd0, state}, {5'd0, ST_FLT});
        chk("inv_fault", {7'd0, fault}, 8'h01);
        chk("inv_duty", {4'd0, duty}, 8'h00);
        chk("inv_code", {6'd0, flt_code}, 8'h01);
        h = 3'b001;
        tick(5);
        chk("inv_hold", {4'd0, fault, state}, {4'd0, 1'b1, ST_FLT});
        chk("inv_hold_code", {6'd0, flt_code}, 8'h01);
        en = 1'b0;
        tick(1);
        chk("inv_exit", {5'd0, state}, {5'd0, ST_IDLE});
        chk("inv_exit_code", {5'd0, fault, flt_code}, 8'h00);

        // Stall: HS sees 011 after 2 edges, counter clears on the 3rd,
        // reaches 63 on the 66th, FAULT on the 67th
        spin_to_run(4'd2);
        freeze_hall();
        tick(66);
        chk("stall_not_yet", {5'd0, state}, {5'd0, ST_RUN});
        tick(1);
        chk("stall_state", {5'd0, state}, {5'd0, ST_FLT});
        chk("stall_code", {6'd0, flt_code}, 8'h02);
        chk("stall_duty", {4'd0, duty}, 8'h00);
        en = 1'b0;
        tick(1);
        chk("stall_exit", {6'd0, flt_code}, 8'h00);

        // Stall and invalid Hall on the same cycle: invalid wins
        spin_to_run(4'd2);
        freeze_hall();
        tick(64);
        h = 3'b000;
        tick(2);
        chk("both_not_yet", {5'd0, state}, {5'd0, ST_RUN});
        tick(1);
        chk("both_state", {5'd0, state}, {5'd0, ST_FLT});
        chk("both_code", {6'd0, flt_code}, 8'h01);
        en = 1'b0;
        tick(1);
        chk("both_exit", {5'd0, state}, {5'd0, ST_IDLE});

        // Reset mid-ramp at duty 5
        h = hseq[hidx];
        spin = 1'b1;
        tick(3);
        en = 1'b1;
        target = 4'd8;
        tick(21);
        chk("mr_duty5", {4'd0, duty}, 8'h05);
        chk("mr_ramp", {5'd0, state}, {5'd0, ST_RAMP});
        rst_n = 1'b0;
        #1;
        chk("mr_async_duty", {4'd0, duty}, 8'h00);
        chk("mr_async_state", {5'd0, state}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("mr_restart", {5'd0, state}, {5'd0, ST_RAMP});
        chk("mr_restart_duty", {4'd0, duty}, 8'h00);
        // HS still carries the reset value 000 during the first RAMP cycle
        tick(1);
        chk("mr_sync_fault", {6'd0, flt_code}, 8'h01);
        en = 1'b0;
        tick(1);
        chk("mr_exit", {5'd0, state}, {5'd0, ST_IDLE});

        // Saturation at 15, then back down to 0 while staying in RUN
        spin_to_run(4'd15);
        tick(8);
        chk("sat_hold", {4'd0, duty}, 8'h0F);
        target = 4'd0;
        tick(62);
        chk("zero_run", {5'd0, state}, {5'd0, ST_RUN});
        chk("zero_duty", {4'd0, duty}, 8'h00);
        spin = 1'b0;
        tick(80);
        chk("zero_nostall", {4'd0, fault, state}, {4'd0, 1'b0, ST_RUN});
        chk("zero_nowrap", {4'd0, duty}, 8'h00);
        en = 1'b0;
        tick(1);
        chk("zero_stop", {5'd0, state}, {5'd0, ST_STOP});
        tick(1);
        chk("zero_idle", {5'd0, state}, {5'd0, ST_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 1000, clocks per one-LSB duty step; legal range 2..65535.
REQ-002 Parameter STALL_LIMIT, default 100000, clocks without a Hall transition before stall fault; legal range 4..2^20-1.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  run request; 1 = spin up or run, 0 = spin down and stop.
REQ-006 TARGET  input  4  requested duty, 0..15; drives the PWM stage's 4-bit Input.
REQ-007 H  input  3  raw Hall sensor bus, asynchronous to CLK.
REQ-008 DUTY  output  4  registered duty command to the PWM stage's Input port.
REQ-009 STATE  output  3  current FSM state encoding.
REQ-010 FAULT  output  1  1 while in FAULT state.
REQ-011 FLT_CODE  output  2  latched fault cause: 00 none, 01 invalid Hall, 10 stall.

Function
REQ-012 H shall pass through a 2-flop synchronizer; all Hall logic uses the synchronized value HS; HS_prev is HS delayed one clock.
REQ-013 Hall transition = HS != HS_prev; invalid Hall = HS == 000 or HS == 111.
REQ-014 FSM states and encodings: IDLE=000, RAMP=001, RUN=010, STOP=011, FAULT=100; STATE shall equal the register, never decoded.
REQ-015 IDLE: DUTY=0; EN=1 and TARGET!=0 -> RAMP next cycle; EN=1 and TARGET=0 stays IDLE.
REQ-016 RAMP: ramp counter counts 0..RAMP_DIV-1; on the cycle it equals RAMP_DIV-1, DUTY moves one LSB toward TARGET (up or down) and the counter returns to 0.
REQ-017 RAMP -> RUN on the cycle DUTY==TARGET (after or without a step); the counter clears.
REQ-018 RUN: DUTY held; TARGET!=DUTY -> RAMP next cycle with counter from 0.
REQ-019 EN=0 in RAMP or RUN -> STOP next cycle; the ramp counter is not cleared on a RAMP->STOP transition.
REQ-020 STOP: DUTY steps down one LSB every RAMP_DIV cycles; DUTY==0 -> IDLE; EN=1 in STOP -> RAMP next cycle with DUTY unchanged.
REQ-021 DUTY shall never wrap: no decrement below 0, no increment above 15.
REQ-022 Stall counter (20 bits) clears in IDLE, in FAULT, on every Hall transition, and whenever DUTY==0; otherwise it increments, saturating.
REQ-023 Stall counter == STALL_LIMIT-1 in RAMP, RUN or STOP -> FAULT next cycle, FLT_CODE=10.
REQ-024 Invalid Hall in RAMP, RUN or STOP -> FAULT next cycle, FLT_CODE=01; IDLE ignores Hall value.
REQ-025 Invalid Hall and stall on the same cycle -> FLT_CODE=01 (invalid Hall wins).
REQ-026 Fault detection shall take priority over every other transition, including EN=0 and TARGET change.
REQ-027 FAULT: DUTY forced to 0 on entry (same edge as state change); FAULT=1; FLT_CODE held.
REQ-028 FAULT exit only with EN=0 sampled -> IDLE next cycle; FLT_CODE cleared on that exit.
REQ-029 FAULT is held while EN stays 1, regardless of Hall activity.

Reset
REQ-030 RST=0 shall immediately force STATE=IDLE, DUTY=0, FAULT=0, FLT_CODE=00, clear the ramp and stall counters, and set the synchronizer flops and HS_prev to 000.
REQ-031 Reset assertion mid-ramp or in FAULT shall behave identically to power-on reset; deassertion is taken synchronously to CLK, with the first transition no earlier than the next rising edge.

Verification (RAMP_DIV=4, STALL_LIMIT=64)
REQ-032 Spin-up: reset, EN=1, TARGET=8, Hall rotating 001,011,010,110,100,101 every 20 clocks -> DUTY steps 0..8 every 4 clocks; RUN at DUTY=8; no fault.
REQ-033 Retarget/stop: in RUN at 8, TARGET=3 -> RAMP, DUTY down to 3, RUN; then EN=0 -> STOP, DUTY to 0 in 12 clocks, IDLE.
REQ-034 Invalid Hall: in RUN, force H=111 -> after 2 synchronizer clocks plus 1, FAULT=1, DUTY=0, FLT_CODE=01; EN held 1 keeps FAULT; EN=0 -> IDLE, FLT_CODE=00.
REQ-035 Stall: in RUN, freeze H at 011 -> FAULT exactly 64 clocks after the last transition is seen on HS, FLT_CODE=10; simultaneous H=000 at that cycle gives FLT_CODE=01.
REQ-036 Reset mid-ramp: RST=0 at DUTY=5 in RAMP -> DUTY=0, STATE=000 without a clock edge; release with EN=1 -> ramp restarts from 0.
REQ-037 Saturation: TARGET=15 -> DUTY stops at 15, never wraps to 0; TARGET=0 with EN=1 from RUN -> DUTY to 0 and stays in RUN at DUTY 0, stall counter held cleared.
